// File: rtl/prog_loader.sv
// Streams 32-bit instruction words into instruction memory, then releases the core.
// Holds the core in reset until a complete, terminated program has been written.
module prog_loader #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [63:0] BASE_ADDR = 64'h0
) (
    input  logic        Clk,
    input  logic        En,
    input  logic        start,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    input  logic        s_last,
    output logic        s_ready,
    output logic        imem_we,
    output logic [63:0] imem_addr,
    output logic [63:0] imem_wdata,
    output logic        cpu_run,
    output logic        done,
    output logic        err,
    output logic [15:0] count
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE,
        ERR
    } state_t;

    localparam logic [15:0] LAST_SLOT = 16'(DEPTH - 1);

    state_t state;
    logic   xfer;

    assign xfer = s_valid && s_ready;

    // NOTE: every register here is assigned with <= so all of them update
    // together from pre-edge values; reset is sampled on the edge, not async.
    always_ff @(posedge Clk) begin
        if (!En) begin
            state      <= IDLE;
            count      <= 16'd0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= 64'h0;
            s_ready    <= 1'b0;
            cpu_run    <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                IDLE, ERR: begin
                    if (start) begin
                        state   <= LOAD;
                        count   <= 16'd0;
                        s_ready <= 1'b1;
                        err     <= 1'b0;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        // The write is issued from registers, one cycle after the handshake.
                        imem_we    <= 1'b1;
                        imem_addr  <= BASE_ADDR + {46'h0, count, 2'b00};
                        imem_wdata <= {32'h0, s_data};
                        count      <= count + 16'd1;
                        if (s_last) begin
                            state   <= DONE;
                            s_ready <= 1'b0;
                            done    <= 1'b1;
                            cpu_run <= 1'b1;
                        end else if (count == LAST_SLOT) begin
                            state   <= ERR;
                            s_ready <= 1'b0;
                            err     <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Terminal until reset; start is deliberately ignored.
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed and random loads on a default-size and a 4-deep instance,
// compared against a write-list model derived from program length, termination and depth.
module tb_prog_loader;

    localparam int          DEPTH_A = 256;
    localparam logic [63:0] BASE_A  = 64'h0;
    localparam int          DEPTH_B = 4;
    localparam logic [63:0] BASE_B  = 64'h100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        en_a, en_b, start, s_valid, s_last;
    logic [31:0] s_data;

    logic        rdy_a, we_a, run_a, done_a, err_a;
    logic [63:0] addr_a, wdata_a;
    logic [15:0] cnt_a;
    logic        rdy_b, we_b, run_b, done_b, err_b;
    logic [63:0] addr_b, wdata_b;
    logic [15:0] cnt_b;

    prog_loader #(.DEPTH(DEPTH_A), .BASE_ADDR(BASE_A)) dut_a (
        .Clk(clk), .En(en_a), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_last(s_last), .s_ready(rdy_a), .imem_we(we_a), .imem_addr(addr_a),
        .imem_wdata(wdata_a), .cpu_run(run_a), .done(done_a), .err(err_a), .count(cnt_a)
    );

    prog_loader #(.DEPTH(DEPTH_B), .BASE_ADDR(BASE_B)) dut_b (
        .Clk(clk), .En(en_b), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_last(s_last), .s_ready(rdy_b), .imem_we(we_b), .imem_addr(addr_b),
        .imem_wdata(wdata_b), .cpu_run(run_b), .done(done_b), .err(err_b), .count(cnt_b)
    );

    // Only one instance is out of reset at a time; sel picks which one is being observed.
    bit sel;
    logic        cur_ready, cur_run, cur_done, cur_err;
    logic [15:0] cur_count;
    assign cur_ready = sel ? rdy_b  : rdy_a;
    assign cur_run   = sel ? run_b  : run_a;
    assign cur_done  = sel ? done_b : done_a;
    assign cur_err   = sel ? err_b  : err_a;
    assign cur_count = sel ? cnt_b  : cnt_a;

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] data;
    } wr_t;

    wr_t         wq[$];
    logic [31:0] prog[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    always @(negedge clk) begin
        if (we_a) wq.push_back('{addr: addr_a, data: wdata_a});
        if (we_b) wq.push_back('{addr: addr_b, data: wdata_b});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset(input bit which);
        @(negedge clk);
        if (which) en_b = 1'b0; else en_a = 1'b0;
        repeat (2) @(negedge clk);
        if (which) en_b = 1'b1; else en_a = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offers every word of prog; the model says how many get written and how the load ends.
    task automatic run_load(input bit has_last, input int gap_min, input int gap_max);
        int          depth    = sel ? DEPTH_B : DEPTH_A;
        logic [63:0] base     = sel ? BASE_B : BASE_A;
        int          n        = prog.size();
        int          accepted = 0;
        int          exp_acc  = (n < depth) ? n : depth;
        bit          exp_done = has_last && (n <= depth);
        wq.delete();
        pulse_start();
        check("ready_after_start", cur_ready, 1);
        check("count_cleared", cur_count, 0);
        for (int i = 0; i < n; i++) begin
            int gap = $urandom_range(gap_max, gap_min);
            int k   = 0;
            s_valid = 1'b0;
            repeat (gap) @(negedge clk);
            s_valid = 1'b1;
            s_data  = prog[i];
            s_last  = has_last && (i == n - 1);
            while (!cur_ready && k < 3) begin
                @(negedge clk);
                k++;
            end
            if (!cur_ready) break;
            @(negedge clk);
            accepted++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (3) @(negedge clk);
        check("accepted", accepted, exp_acc);
        check("write_count", wq.size(), exp_acc);
        for (int i = 0; i < exp_acc && i < wq.size(); i++) begin
            check("wr_addr", wq[i].addr, base + 64'(4 * i));
            check("wr_data", wq[i].data, {32'h0, prog[i]});
        end
        check("count", cur_count, exp_acc);
        check("done", cur_done, exp_done);
        check("err", cur_err, !exp_done);
        check("cpu_run", cur_run, exp_done);
        check("ready_after", cur_ready, 0);
    endtask

    task automatic random_prog(input int n);
        prog.delete();
        for (int i = 0; i < n; i++) prog.push_back($urandom);
    endtask

    initial begin
        en_a = 1'b0; en_b = 1'b0; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        sel = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_count_a", cnt_a, 0);
        check("rst_we_a", we_a, 0);
        check("rst_addr_a", addr_a, BASE_A);
        check("rst_wdata_a", wdata_a, 0);
        check("rst_flags_a", {rdy_a, run_a, done_a, err_a}, 0);
        check("rst_addr_b", addr_b, BASE_B);
        check("rst_flags_b", {rdy_b, run_b, done_b, err_b}, 0);

        // Idle ignores streamed words without a start.
        en_a = 1'b1;
        s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        s_valid = 1'b0;
        check("idle_no_write", wq.size(), 0);
        check("idle_ready", rdy_a, 0);

        prog = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3};
        run_load(1'b1, 0, 0);

        pulse_start();
        check("done_ignores_start", done_a, 1);
        check("done_ready_low", rdy_a, 0);

        do_reset(1'b0);
        run_load(1'b1, 2, 2);

        // Reset lands on the edge that would have taken the third word.
        do_reset(1'b0);
        wq.delete();
        pulse_start();
        s_valid = 1'b1; s_data = 32'h1111_0001; s_last = 1'b0;
        @(negedge clk);
        s_data = 32'h1111_0002;
        @(negedge clk);
        s_data = 32'h1111_0003;
        en_a = 1'b0;
        @(negedge clk);
        s_valid = 1'b0;
        check("abort_we", we_a, 0);
        check("abort_count", cnt_a, 0);
        check("abort_ready", rdy_a, 0);
        check("abort_addr", addr_a, BASE_A);
        check("abort_wdata", wdata_a, 0);
        check("abort_writes", wq.size(), 2);
        en_a = 1'b1;
        random_prog(3);
        run_load(1'b1, 0, 1);

        for (int r = 0; r < 3; r++) begin
            do_reset(1'b0);
            random_prog($urandom_range(12, 1));
            run_load(1'b1, 0, 3);
        end

        // Small instance: overflow, recovery from ERR, exact fit, then random mixes.
        en_a = 1'b0;
        sel  = 1'b1;
        do_reset(1'b1);
        random_prog(5);
        run_load(1'b0, 0, 0);

        prog = '{32'hCAFE_0001};
        run_load(1'b1, 0, 1);

        do_reset(1'b1);
        random_prog(4);
        run_load(1'b1, 0, 1);

        for (int r = 0; r < 4; r++) begin
            bit hl = 1'($urandom_range(1, 0));
            int n  = $urandom_range(6, 1);
            if (!hl && n < DEPTH_B) n = DEPTH_B + $urandom_range(2, 0);
            do_reset(1'b1);
            random_prog(n);
            run_load(hl, 0, 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter DEPTH, default 256, SHALL be the maximum number of instruction words loadable (2..65535).
REQ-002 Parameter BASE_ADDR, default 64'h0, SHALL be the byte address of the first instruction word written.
REQ-003 Clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 En  input  1  SHALL be the synchronous active-low reset (En=0 at a rising edge resets the block).
REQ-005 start  input  1  SHALL be the request to begin a program load.
REQ-006 s_valid  input  1  SHALL mark s_data/s_last as valid.
REQ-007 s_data  input  32  SHALL be one instruction word.
REQ-008 s_last  input  1  SHALL mark the final word of the program.
REQ-009 s_ready  output  1  SHALL indicate the loader accepts a word this cycle.
REQ-010 imem_we  output  1  SHALL be the instruction-memory write strobe.
REQ-011 imem_addr  output  64  SHALL be the instruction-memory byte address.
REQ-012 imem_wdata  output  64  SHALL be the instruction-memory write data.
REQ-013 cpu_run  output  1  SHALL release the core (drives pc_reset); 0 holds the core in reset.
REQ-014 done  output  1  SHALL indicate a successful, complete load.
REQ-015 err  output  1  SHALL indicate an overflowed load.
REQ-016 count  output  16  SHALL be the number of words written in the current/last load.

Function
REQ-017 States SHALL be IDLE, LOAD, DONE, ERR; all outputs SHALL be registered.
REQ-018 IDLE: s_ready=0, cpu_run=0, done=0, err=0; start=1 SHALL move to LOAD and clear count to 0.
REQ-019 LOAD: s_ready SHALL be 1; a transfer occurs only when s_valid=1 and s_ready=1 at a rising edge.
REQ-020 Each transfer SHALL, one cycle later, pulse imem_we=1 for exactly one cycle with imem_addr=BASE_ADDR+4*count_before and imem_wdata={32'h0,s_data}, and increment count.
REQ-021 imem_we SHALL be 0 in every cycle not following a transfer; imem_addr/imem_wdata SHALL hold their last values when imem_we=0.
REQ-022 s_valid=0 in LOAD SHALL insert idle cycles with no state change; no timeout.
REQ-023 A transfer with s_last=1 SHALL move LOAD to DONE at the same edge; that word is still written.
REQ-024 A transfer with s_last=0 when count_before=DEPTH-1 SHALL write the word and move to ERR (memory full, program unterminated).
REQ-025 A transfer with s_last=1 when count_before=DEPTH-1 SHALL move to DONE (exact fit is legal).
REQ-026 s_ready SHALL be 0 in the cycle after the transition out of LOAD.
REQ-027 DONE: done=1, cpu_run=1, s_ready=0; start SHALL be ignored; state held until reset.
REQ-028 ERR: err=1, cpu_run=0, s_ready=0; start=1 SHALL move to LOAD, clear count, and clear err.
REQ-029 start in LOAD SHALL be ignored; s_valid outside LOAD SHALL be ignored.
REQ-030 cpu_run SHALL never be 1 in any state other than DONE.

Reset
REQ-031 En=0 at a rising edge SHALL force IDLE, count=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, s_ready=0, cpu_run=0, done=0, err=0.
REQ-032 Reset mid-LOAD SHALL abort the load; any pending imem_we pulse SHALL be suppressed.
REQ-033 Reset SHALL take priority over start and transfers in the same cycle.

Verification
REQ-034 Reset, start, 3 words 0x00500093/0x00A00113/0x002081B3 (last on 3rd), back-to-back -> imem_we pulses at addresses 0,4,8 with those data, count=3, done=1, cpu_run=1.
REQ-035 Same 3 words with s_valid gaps of 2 cycles -> identical writes, no extra imem_we pulses, done=1.
REQ-036 DEPTH=4, 5 words offered, no s_last -> 4 writes (0..12), err=1, s_ready=0 after 4th, 5th word not accepted, cpu_run=0.
REQ-037 DEPTH=4, 4 words with s_last on 4th -> done=1, err=0, count=4.
REQ-038 En=0 after 2nd transfer of a load -> no further imem_we, IDLE, count=0; new start reloads from address 0.
REQ-039 From ERR, start then 1 word with s_last -> err=0, write at BASE_ADDR, count=1, done=1.
